// File: rtl/uart_program_loader.sv
// UART 8N1 program loader: receives SYNC + DEPTH-byte image + checksum into a
// local buffer, then burst-writes the image to RAM only when the checksum matches.
module uart_program_loader #(
    parameter int unsigned CLK_FREQ  = 27000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rx,
    input  logic                     enable,
    output logic                     ram_we,
    output logic [$clog2(DEPTH)-1:0] ram_addr,
    output logic [7:0]               ram_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CPB  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB) + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {F_IDLE, F_RECV, F_CHECK, F_COMMIT} f_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ferr_q, rx_ferr_d;

    f_state_e      f_state_q, f_state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    data_q, data_d;
    logic          we_q, we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          store_c;
    logic [7:0]    mem_q [DEPTH];

    // Synchroniser and edge history preset to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Mid start bit: a high line here was only a glitch
                if (rx_cnt_q == CW'(HALF - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CW'(CPB - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CW'(CPB - 1)) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_state_q <= F_IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            csum_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            f_state_q <= f_state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            csum_q    <= csum_d;
            data_q    <= data_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Image buffer; contents are don't-care until a frame is received
    always_ff @(posedge clk) begin
        if (store_c) begin
            mem_q[idx_q] <= rx_shift_q;
        end
    end

    always_comb begin
        f_state_d = f_state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        csum_d    = csum_q;
        data_d    = data_q;
        we_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        store_c   = 1'b0;
        case (f_state_q)
            F_IDLE: begin
                if (rx_valid_q && enable && (rx_shift_q == SYNC_BYTE)) begin
                    error_d   = 1'b0;
                    csum_d    = '0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    f_state_d = F_RECV;
                end
            end
            F_RECV: begin
                if (!enable) begin
                    busy_d    = 1'b0;
                    f_state_d = F_IDLE;
                end else if (rx_ferr_q) begin
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    f_state_d = F_IDLE;
                end else if (rx_valid_q) begin
                    store_c = 1'b1;
                    csum_d  = csum_q + rx_shift_q;
                    idx_d   = idx_q + AW'(1);
                    if (idx_q == AW'(DEPTH - 1)) begin
                        f_state_d = F_CHECK;
                    end
                end
            end
            F_CHECK: begin
                if (!enable) begin
                    busy_d    = 1'b0;
                    f_state_d = F_IDLE;
                end else if (rx_ferr_q) begin
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    f_state_d = F_IDLE;
                end else if (rx_valid_q) begin
                    if (rx_shift_q == csum_q) begin
                        we_d      = 1'b1;
                        addr_d    = '0;
                        data_d    = mem_q[0];
                        f_state_d = F_COMMIT;
                    end else begin
                        error_d   = 1'b1;
                        busy_d    = 1'b0;
                        f_state_d = F_IDLE;
                    end
                end
            end
            F_COMMIT: begin
                // RX bytes and enable are ignored until the burst finishes
                if (addr_q == AW'(DEPTH - 1)) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    f_state_d = F_IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + AW'(1);
                    data_d = mem_q[addr_d];
                end
            end
            default: f_state_d = F_IDLE;
        endcase
    end

    assign ram_we   = we_q;
    assign ram_addr = addr_q;
    assign ram_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: frame table, hand-written corner sequences and
// random frames checked against a byte-stream reference model.
module tb_uart_program_loader;

    localparam int unsigned CLK_FREQ = 1600000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned CPB      = CLK_FREQ / BAUD;
    localparam logic [7:0]  SYNC     = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       enable = 1'b1;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       busy;
    logic       done;
    logic       error;

    uart_program_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .SYNC_BYTE(SYNC),
        .DEPTH    (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .enable  (enable),
        .ram_we  (ram_we),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] pl;
        logic [7:0]   cs;
        bit           exp_load;
        bit           exp_err;
    } vec_t;

    vec_t       tbl[6];
    int         n_total = 0;
    int         n_pass  = 0;
    int         cyc     = 0;
    int         done_cnt = 0;
    int         wr_addr[$];
    int         wr_data[$];
    int         wr_cyc[$];
    logic [7:0] dut_ram [16];
    logic [7:0] model_ram [16];

    // Write-port observer, sampled on the falling edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ram_we === 1'b1) begin
            wr_addr.push_back(int'(ram_addr));
            wr_data.push_back(int'(ram_data));
            wr_cyc.push_back(cyc);
            dut_ram[ram_addr] = ram_data;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = s + 8'(k);
        return r;
    endfunction

    function automatic logic [7:0] good_cs(input logic [127:0] pl);
        int unsigned sum = 0;
        for (int k = 0; k < 16; k++) sum += int'(pl[8*k +: 8]);
        return 8'(sum % 256);
    endfunction

    // Reference: first SYNC in the stream, 16 payload bytes, then checksum
    function automatic void ref_model(input logic [7:0] s[$], output bit load,
                                      output bit err, output logic [127:0] img);
        int          p   = -1;
        int unsigned sum = 0;
        load = 1'b0;
        err  = 1'b0;
        img  = '0;
        for (int i = 0; i < s.size(); i++) if (p < 0 && s[i] == SYNC) p = i;
        if (p >= 0 && s.size() >= p + 18) begin
            for (int k = 0; k < 16; k++) begin
                img[8*k +: 8] = s[p + 1 + k];
                sum += int'(s[p + 1 + k]);
            end
            load = ((sum % 256) == int'(s[p + 17]));
            err  = !load;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [127:0] pl, input logic [7:0] cs);
        send_byte(SYNC, 1'b1);
        chk("busy_after_sync", int'(busy), 1);
        chk("err_clear_on_sync", int'(error), 0);
        for (int k = 0; k < 16; k++) send_byte(pl[8*k +: 8], 1'b1);
        send_byte(cs, 1'b1);
    endtask

    task automatic clear_log();
        @(negedge clk);
        #1;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic check_frame(input string nm, input bit exp_load, input bit exp_err,
                               input logic [127:0] pl);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".settle"}, int'(n < 300), 1);
        repeat (4) @(negedge clk);
        #1;
        chk({nm, ".nwr"}, wr_addr.size(), exp_load ? 16 : 0);
        if (exp_load && wr_addr.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("%s.addr[%0d]", nm, k), wr_addr[k], k);
                chk($sformatf("%s.data[%0d]", nm, k), wr_data[k], int'(pl[8*k +: 8]));
            end
            chk({nm, ".span"}, wr_cyc[15] - wr_cyc[0], 15);
        end
        chk({nm, ".done"}, done_cnt, exp_load ? 1 : 0);
        chk({nm, ".error"}, int'(error), int'(exp_err));
        chk({nm, ".busy"}, int'(busy), 0);
    endtask

    task automatic wait_writes(input int target, output bit ok);
        int n = 0;
        while (wr_addr.size() < target && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (wr_addr.size() >= target);
    endtask

    task automatic seq_framing();
        logic [127:0] pl = ramp(8'h00);
        clear_log();
        send_byte(SYNC, 1'b1);
        for (int k = 0; k < 5; k++) send_byte(pl[8*k +: 8], 1'b1);
        send_byte(pl[47:40], 1'b0);
        repeat (10) @(negedge clk);
        #1;
        chk("ferr.error", int'(error), 1);
        chk("ferr.busy", int'(busy), 0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        chk("noise.error_kept", int'(error), 1);
        chk("noise.busy", int'(busy), 0);
        chk("noise.nwr", wr_addr.size(), 0);
        pl = ramp(8'h33);
        clear_log();
        send_frame(pl, good_cs(pl));
        check_frame("after_ferr", 1'b1, 1'b0, pl);
    endtask

    task automatic seq_glitch();
        logic [127:0] pl = ramp(8'h40);
        clear_log();
        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("glitch.busy", int'(busy), 0);
        chk("glitch.error", int'(error), 0);
        send_frame(pl, good_cs(pl));
        check_frame("after_glitch", 1'b1, 1'b0, pl);
    endtask

    task automatic seq_reset_commit();
        logic [127:0] pl = ramp(8'h50);
        bit           ok;
        clear_log();
        fork
            send_frame(pl, good_cs(pl));
            begin
                wait_writes(7, ok);
                chk("rst.reach_write7", int'(ok), 1);
                rst = 1'b1;
                #1;
                chk("rst.ram_we", int'(ram_we), 0);
                chk("rst.busy", int'(busy), 0);
                chk("rst.done", int'(done), 0);
                chk("rst.addr", int'(ram_addr), 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (40) @(negedge clk);
        #1;
        chk("rst.nwr", wr_addr.size(), 7);
        chk("rst.done_cnt", done_cnt, 0);
        chk("rst.error", int'(error), 0);
    endtask

    task automatic seq_enable_abort();
        logic [127:0] pl = ramp(8'h60);
        clear_log();
        send_byte(SYNC, 1'b1);
        for (int k = 0; k < 9; k++) send_byte(pl[8*k +: 8], 1'b1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("en_abort.busy", int'(busy), 0);
        chk("en_abort.error", int'(error), 0);
        for (int k = 9; k < 16; k++) send_byte(pl[8*k +: 8], 1'b1);
        send_byte(good_cs(pl), 1'b1);
        repeat (30) @(negedge clk);
        #1;
        chk("en_abort.nwr", wr_addr.size(), 0);
        chk("en_abort.done", done_cnt, 0);
        chk("en_abort.error_kept", int'(error), 0);
        enable = 1'b1;
    endtask

    task automatic seq_enable_in_commit();
        logic [127:0] pl = ramp(8'h70);
        bit           ok;
        clear_log();
        fork
            send_frame(pl, good_cs(pl));
            begin
                wait_writes(3, ok);
                chk("en_commit.reach_write3", int'(ok), 1);
                enable = 1'b0;
            end
        join
        check_frame("en_commit", 1'b1, 1'b0, pl);
        enable = 1'b1;
    endtask

    task automatic seq_random();
        for (int r = 0; r < 4; r++) begin
            logic [7:0]   s[$];
            logic [127:0] pl;
            logic [127:0] img;
            logic [7:0]   b;
            bit           load;
            bit           err;
            int           nn = $urandom_range(0, 2);
            for (int i = 0; i < nn; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h5A;
                s.push_back(b);
            end
            for (int k = 0; k < 16; k++) pl[8*k +: 8] = 8'($urandom_range(0, 255));
            s.push_back(SYNC);
            for (int k = 0; k < 16; k++) s.push_back(pl[8*k +: 8]);
            if (r == 0 || $urandom_range(0, 1) == 1) s.push_back(good_cs(pl));
            else s.push_back(8'($urandom_range(0, 255)));
            ref_model(s, load, err, img);
            clear_log();
            for (int i = 0; i < s.size(); i++) send_byte(s[i], 1'b1);
            check_frame($sformatf("rand%0d", r), load, err, img);
            if (load) for (int k = 0; k < 16; k++) model_ram[k] = img[8*k +: 8];
        end
        for (int k = 0; k < 16; k++)
            chk($sformatf("ram_image[%0d]", k), int'(dut_ram[k]), int'(model_ram[k]));
    endtask

    initial begin
        tbl[0] = '{"good_ramp",      ramp(8'h00),     8'h78, 1'b1, 1'b0};
        tbl[1] = '{"bad_cs_11",      {16{8'h11}},     8'h00, 1'b0, 1'b1};
        tbl[2] = '{"good_after_bad", ramp(8'h00),     8'h78, 1'b1, 1'b0};
        tbl[3] = '{"bad_cs_off1",    ramp(8'h00),     8'h79, 1'b0, 1'b1};
        tbl[4] = '{"all_sync_data",  {16{8'hA5}},     8'h50, 1'b1, 1'b0};
        tbl[5] = '{"good_ramp_f0",   ramp(8'hF0),     8'h78, 1'b1, 1'b0};

        rst     = 1'b1;
        uart_rx = 1'b1;
        enable  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.ram_we", int'(ram_we), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.error", int'(error), 0);
        chk("reset.addr", int'(ram_addr), 0);
        chk("reset.data", int'(ram_data), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            clear_log();
            send_frame(tbl[i].pl, tbl[i].cs);
            check_frame(tbl[i].name, tbl[i].exp_load, tbl[i].exp_err, tbl[i].pl);
        end

        seq_framing();
        seq_glitch();
        seq_reset_commit();
        seq_enable_abort();
        seq_enable_in_commit();
        seq_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Serial front end that programs the 16-byte CPU RAM from a host PC over UART (8N1). It sits directly upstream of RAM/MAR programming, as an alternative source to the switch and bootloader paths.
- Receives a framed 16-byte image into a local buffer and verifies a checksum.
- Only after a good checksum does it burst-write the image to RAM on a write port sampled by the CPU-side memory mux; a bad frame never touches RAM.

Parameters:
- CLK_FREQ, 27000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (234 at defaults).
- SYNC_BYTE, 8'hA5, frame start marker.
- DEPTH, 16, image length in bytes; address width is clog2(DEPTH) = 4.

Ports:
- clk  input  1  system clock (not cpu_clk).
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- enable  input  1  loader may accept a new frame when high.
- ram_we  output  1  one-cycle write strobe per byte during commit.
- ram_addr  output  4  write address.
- ram_data  output  8  write data.
- busy  output  1  high from accepted SYNC through the last commit write.
- done  output  1  one-cycle pulse after the last commit write.
- error  output  1  sticky; set on a bad frame, cleared when the next SYNC is accepted.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, buffer contents don't-care, RX synchroniser preset to 1. Reset is asynchronous and takes effect mid-frame or mid-commit with no further writes.
- RX synchroniser: 2-flop on uart_rx; all logic uses the synchronised copy.
- RX bit engine:
  - A falling edge while line idle starts a counter.
  - At CLKS_PER_BIT/2 the start bit is re-sampled; if high, it is a glitch and the engine returns to idle with no error.
  - Data bits are sampled every CLKS_PER_BIT thereafter, LSB first.
  - The stop bit is sampled one bit period after bit 7. Stop = 0 is a framing error.
  - A completed byte raises an internal rx_valid for 1 cycle.
- Frame FSM:
  - IDLE: ignore bytes while enable=0. A byte == SYNC_BYTE with enable=1 → clear error, clear checksum and index, set busy, go to RECV. Any other byte is discarded.
  - RECV: each byte goes to buf[idx], is added to checksum mod 256, and idx increments. After byte idx=15 → CHECK.
  - CHECK: the next byte is compared to the checksum. Equal → COMMIT with addr=0. Not equal → set error, clear busy, go to IDLE.
  - COMMIT: one write per cycle, ram_we=1, ram_addr=k, ram_data=buf[k], for k=0..15 (16 consecutive cycles). Bytes arriving during COMMIT are ignored. After k=15: ram_we=0, busy=0, done=1 for one cycle, go to IDLE.
- Framing error: in RECV or CHECK → error=1, busy=0, return to IDLE. In IDLE → byte dropped, error unchanged.
- enable falling: in RECV/CHECK → abort to IDLE, busy=0, error unchanged, nothing written. In COMMIT → the commit completes.
- Latency: the first ram_we occurs 1 cycle after rx_valid of the checksum byte.
- A SYNC_BYTE value inside the payload is treated as data.

Test Plan:
- Good frame: send A5, bytes 00..0F, checksum 78 → ram_we asserted for 16 consecutive cycles with addr=data=0..15, then done pulse, busy=0, error=0.
- Bad checksum: A5, sixteen 0x11, checksum 0x00 (expected 0x10) → ram_we never asserted, error=1, busy=0. Then a good frame → error clears on its SYNC and the writes occur.
- Framing error: during byte 5 of a frame, drive the stop bit low → error=1, busy=0, no writes. Noise bytes 3C, 00 before a frame are ignored, and the following good frame loads.
- Start glitch: pulse uart_rx low for 50 clk in idle → no rx_valid, state unchanged. A subsequent good frame loads correctly.
- Reset/enable abort: assert rst during commit cycle 7 → ram_we=0 immediately, all outputs 0. Separately, deassert enable after byte 8 → busy=0, no writes, no done.
- Payload containing A5 at every position with checksum 0x50 → loads all 16 bytes as 0xA5.
